// File: rtl/uart_rx_if.sv
// Receive-side UART signal bundle: serial line in, received byte and status strobes out.
// The receiver uses the slave view; whatever drives the line and consumes the byte uses the master view.
interface uart_rx_if;
   logic       rx;
   logic [7:0] data_out;
   logic       valid;
   logic       frame_err;
   logic       busy;

   modport slave (
      input  rx,
      output data_out,
      output valid,
      output frame_err,
      output busy
   );

   modport master (
      output rx,
      input  data_out,
      input  valid,
      input  frame_err,
      input  busy
   );
endinterface

// File: rtl/uart_rx.sv
// 8N1 oversampling UART receiver: start bit validated at mid-bit, LSB-first data,
// stop bit checked at mid-bit, one-cycle valid / frame_err strobes.
module uart_rx #(
   parameter int CLKFREQ    = 50_000_000,
   parameter int BAUDS      = 9600,
   parameter int OVERSAMPLE = 16
) (
   input  logic     clk,
   input  logic     rst,
   uart_rx_if.slave bus
);
   localparam int DIV_RAW = CLKFREQ / (BAUDS * OVERSAMPLE);
   localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
   localparam int PW      = $clog2(DIV + 1);
   localparam int SW      = $clog2(OVERSAMPLE);
   localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);
   localparam logic [SW-1:0] MID      = SW'(OVERSAMPLE / 2 - 1);
   localparam logic [SW-1:0] LAST     = SW'(OVERSAMPLE - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   state_t        state_r;
   logic          rx_meta_r;
   logic          rx_s;
   logic          rx_d;
   logic [PW-1:0] pcnt_r;
   logic [SW-1:0] scnt_r;
   logic [2:0]    bcnt_r;
   logic [7:0]    shift_r;
   logic [7:0]    data_r;
   logic          valid_r;
   logic          ferr_r;
   logic          busy_r;
   logic          tick_s;

   // Two-flop synchronizer plus one delayed copy for falling-edge detection.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_meta_r <= 1'b1;
         rx_s      <= 1'b1;
         rx_d      <= 1'b1;
      end else begin
         rx_meta_r <= bus.rx;
         rx_s      <= rx_meta_r;
         rx_d      <= rx_s;
      end
   end

   // Prescaler parked at zero while idle so every frame samples with the same phase.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pcnt_r <= {PW{1'b0}};
      end else if (state_r == IDLE) begin
         pcnt_r <= {PW{1'b0}};
      end else if (pcnt_r == PRE_LAST) begin
         pcnt_r <= {PW{1'b0}};
      end else begin
         pcnt_r <= pcnt_r + PW'(1);
      end
   end

   assign tick_s = (state_r != IDLE) && (pcnt_r == PRE_LAST);

   // Frame state machine with registered byte and status outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
         scnt_r  <= {SW{1'b0}};
         bcnt_r  <= 3'd0;
         shift_r <= 8'h00;
         data_r  <= 8'h00;
         valid_r <= 1'b0;
         ferr_r  <= 1'b0;
         busy_r  <= 1'b0;
      end else begin
         valid_r <= 1'b0;
         ferr_r  <= 1'b0;
         case (state_r)
            IDLE: begin
               busy_r <= 1'b0;
               if (rx_d && !rx_s) begin
                  state_r <= START;
                  scnt_r  <= {SW{1'b0}};
                  busy_r  <= 1'b1;
               end
            end
            START: begin
               if (tick_s) begin
                  if (scnt_r == MID) begin
                     scnt_r <= {SW{1'b0}};
                     bcnt_r <= 3'd0;
                     if (rx_s) begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                     end else begin
                        state_r <= DATA;
                     end
                  end else begin
                     scnt_r <= scnt_r + SW'(1);
                  end
               end
            end
            DATA: begin
               if (tick_s) begin
                  if (scnt_r == LAST) begin
                     scnt_r          <= {SW{1'b0}};
                     shift_r[bcnt_r] <= rx_s;
                     bcnt_r          <= bcnt_r + 3'd1;
                     if (bcnt_r == 3'd7) begin
                        state_r <= STOP;
                     end
                  end else begin
                     scnt_r <= scnt_r + SW'(1);
                  end
               end
            end
            STOP: begin
               // Leave at mid-stop so a back-to-back start edge is not missed.
               if (tick_s) begin
                  if (scnt_r == LAST) begin
                     scnt_r  <= {SW{1'b0}};
                     state_r <= IDLE;
                     busy_r  <= 1'b0;
                     if (rx_s) begin
                        data_r  <= shift_r;
                        valid_r <= 1'b1;
                     end else begin
                        ferr_r  <= 1'b1;
                     end
                  end else begin
                     scnt_r <= scnt_r + SW'(1);
                  end
               end
            end
            default: begin
               state_r <= IDLE;
               busy_r  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.data_out  = data_r;
   assign bus.valid     = valid_r;
   assign bus.frame_err = ferr_r;
   assign bus.busy      = busy_r;
endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: table of frames plus hand-written break, glitch and reset cases.
// Baud is scaled so one bit is 64 clocks (DIV = 4, OVERSAMPLE = 16).
module tb_uart_rx;
   localparam int CLKFREQ    = 50_000_000;
   localparam int BAUDS      = 781_250;
   localparam int OVERSAMPLE = 16;
   localparam int BIT        = 64;

   logic clk = 1'b0;
   logic rst;
   always #10 clk = ~clk;

   uart_rx_if bus ();

   uart_rx #(
      .CLKFREQ   (CLKFREQ),
      .BAUDS     (BAUDS),
      .OVERSAMPLE(OVERSAMPLE)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   typedef struct packed {
      logic       err;
      logic [7:0] data;
   } exp_t;

   typedef struct {
      logic [7:0] data;
      logic       stop;
      int         bitlen;
      int         gap;
      logic       exp_err;
      logic [7:0] exp_data;
   } vec_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   logic busy_seen;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic wait_clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_bit(input logic b, input int n);
      bus.rx = b;
      wait_clks(n);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop, input int bitlen);
      send_bit(1'b0, bitlen);
      for (int i = 0; i < 8; i++) send_bit(d[i], bitlen);
      send_bit(stop, bitlen);
      bus.rx = 1'b1;
   endtask

   // Scoreboard: every strobe must match the oldest expected frame result.
   always @(negedge clk) begin
      exp_t e;
      if (rst === 1'b0 && (bus.valid === 1'b1 || bus.frame_err === 1'b1)) begin
         check("pulse_exclusive", {31'd0, bus.valid & bus.frame_err}, 32'd0);
         check("busy_at_pulse", {31'd0, bus.busy}, 32'd0);
         if (sb.size() == 0) begin
            check("unexpected_pulse", 32'(sb.size()), 32'd1);
         end else begin
            e = sb.pop_front();
            check("pulse_kind", {31'd0, bus.frame_err}, {31'd0, e.err});
            check("data_out", {24'd0, bus.data_out}, {24'd0, e.data});
         end
      end
   end

   always @(negedge clk) begin
      if (bus.busy === 1'b1) busy_seen = 1'b1;
   end

   vec_t vecs[11];

   initial begin
      vecs[0]  = '{8'hA5, 1'b1, 64, 100, 1'b0, 8'hA5};
      vecs[1]  = '{8'h3C, 1'b1, 64, 200, 1'b0, 8'h3C};
      vecs[2]  = '{8'h55, 1'b0, 64, 100, 1'b1, 8'h3C};
      vecs[3]  = '{8'h00, 1'b1, 64,   0, 1'b0, 8'h00};
      vecs[4]  = '{8'hFF, 1'b1, 64, 100, 1'b0, 8'hFF};
      vecs[5]  = '{8'h00, 1'b1, 65,   0, 1'b0, 8'h00};
      vecs[6]  = '{8'hFF, 1'b1, 65, 100, 1'b0, 8'hFF};
      vecs[7]  = '{8'h00, 1'b1, 63,   0, 1'b0, 8'h00};
      vecs[8]  = '{8'hFF, 1'b1, 63, 100, 1'b0, 8'hFF};
      vecs[9]  = '{8'h81, 1'b0, 64, 100, 1'b1, 8'hFF};
      vecs[10] = '{8'h7E, 1'b1, 64, 100, 1'b0, 8'h7E};

      bus.rx    = 1'b1;
      busy_seen = 1'b0;
      rst       = 1'b1;
      wait_clks(5);
      check("reset_data_out", {24'd0, bus.data_out}, 32'd0);
      check("reset_valid", {31'd0, bus.valid}, 32'd0);
      check("reset_frame_err", {31'd0, bus.frame_err}, 32'd0);
      check("reset_busy", {31'd0, bus.busy}, 32'd0);
      rst = 1'b0;
      wait_clks(20);

      for (int v = 0; v < 11; v++) begin
         sb.push_back('{vecs[v].exp_err, vecs[v].exp_data});
         busy_seen = 1'b0;
         send_frame(vecs[v].data, vecs[v].stop, vecs[v].bitlen);
         check("busy_during_frame", {31'd0, busy_seen}, 32'd1);
         check("busy_after_frame", {31'd0, bus.busy}, 32'd0);
         check("frame_result_seen", 32'(sb.size()), 32'd0);
         wait_clks(vecs[v].gap);
      end

      // Short low glitch: rejected at mid start bit.
      bus.rx = 1'b0;
      wait_clks(12);
      check("glitch_busy", {31'd0, bus.busy}, 32'd1);
      bus.rx = 1'b1;
      wait_clks(40);
      check("glitch_busy_clear", {31'd0, bus.busy}, 32'd0);
      sb.push_back('{1'b0, 8'h3C});
      send_frame(8'h3C, 1'b1, BIT);
      check("after_glitch_rx", 32'(sb.size()), 32'd0);
      wait_clks(100);

      // Long break: one framing error, no retrigger while the line stays low.
      sb.push_back('{1'b1, 8'h3C});
      bus.rx = 1'b0;
      wait_clks(2000);
      check("break_one_ferr", 32'(sb.size()), 32'd0);
      check("break_busy", {31'd0, bus.busy}, 32'd0);
      bus.rx = 1'b1;
      wait_clks(100);

      // Reset during data bit 4 of 0xA5.
      send_bit(1'b0, BIT);
      for (int i = 0; i < 4; i++) send_bit(1'b1 & (8'hA5 >> i), BIT);
      send_bit(1'b0, BIT / 2);
      rst = 1'b1;
      #1;
      check("abort_data_out", {24'd0, bus.data_out}, 32'd0);
      check("abort_valid", {31'd0, bus.valid}, 32'd0);
      check("abort_frame_err", {31'd0, bus.frame_err}, 32'd0);
      check("abort_busy", {31'd0, bus.busy}, 32'd0);
      wait_clks(5);
      bus.rx = 1'b1;
      rst    = 1'b0;
      wait_clks(700);
      check("abort_no_pulse", 32'(sb.size()), 32'd0);
      sb.push_back('{1'b0, 8'h3C});
      send_frame(8'h3C, 1'b1, BIT);
      check("after_reset_rx", 32'(sb.size()), 32'd0);
      wait_clks(50);
      check("final_data_out", {24'd0, bus.data_out}, 32'h3C);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Asynchronous serial receiver; the receive-side counterpart of the team's UART transmitter top (8N1, LSB first, idle-high line).
- Oversamples the `rx` line, validates the start bit at mid-bit and shifts in 8 data bits.
- Checks the stop bit, then presents the byte with a single-cycle strobe.
- Sits at the chip pin boundary, alongside the TX path, sharing the same `CLKFREQ`/`BAUDS` parameters.

Parameters:
- `CLKFREQ`, 50_000_000, system clock frequency in Hz.
- `BAUDS`, 9600, line rate in bits/s.
- `OVERSAMPLE`, 16, sample ticks per bit period; must be even and ≥ 4.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `rx`  in  1  serial input; asynchronous to `clk`, idle high.
- `data_out`  out  8  last received byte; held until the next frame completes.
- `valid`  out  1  one-clk pulse: `data_out` was updated by a good frame.
- `frame_err`  out  1  one-clk pulse: stop bit sampled low.
- `busy`  out  1  high while a frame is in progress (START/DATA/STOP).

Behaviour:
- Reset values: `data_out`=8'h00, `valid`=0, `frame_err`=0, `busy`=0, state=IDLE.
  - Synchronizer flops reset to 1; prescaler and counters reset to 0.
  - Reset asserted mid-frame aborts the frame immediately, with no `valid` or `frame_err`.
- Synchronizer: `rx` passes through 2 flops (`rx_s`). All decisions use `rx_s` and its 1-clk delayed copy `rx_d`.
- Prescaler:
  - DIV = CLKFREQ/(BAUDS*OVERSAMPLE), integer division (325 at the defaults).
  - `tick` pulses for 1 clk every DIV clks.
  - The prescaler is held at 0 in IDLE and restarts from 0 on start-edge detection, so sample phase is deterministic.
- Tick counter: `scnt`, width clog2(OVERSAMPLE), counts ticks within a bit. Bit counter: `bcnt`, 3 bits.
- IDLE:
  - `busy`=0.
  - Falling edge (`rx_d`=1, `rx_s`=0) -> START, `scnt`=0.
  - A line held low (break) does not retrigger; a new falling edge is required.
- START:
  - `busy`=1.
  - On the tick where `scnt` reaches OVERSAMPLE/2-1 (mid start bit):
    - `rx_s`=1 -> glitch; go to IDLE with no outputs.
    - `rx_s`=0 -> DATA, `scnt`=0, `bcnt`=0.
- DATA:
  - Every OVERSAMPLE ticks (`scnt` wraps at OVERSAMPLE-1), sample `rx_s` into shift register bit `bcnt` (LSB first).
  - After `bcnt`=7 is sampled -> STOP.
- STOP:
  - After OVERSAMPLE ticks, sample `rx_s`.
  - `rx_s`=1: `data_out` <= shifted byte, `valid`=1 for exactly the next clk.
  - `rx_s`=0: `data_out` unchanged, `frame_err`=1 for exactly the next clk.
  - In both cases go to IDLE immediately at mid-stop-bit, which tolerates back-to-back frames and up to about ±3% baud mismatch.
- Latency: `valid`/`frame_err` assert 1 clk after the stop-bit sample tick, i.e. about 9.5 bit periods after the start-bit falling edge.
- `valid` and `frame_err` are mutually exclusive and never assert outside that cycle.
- `busy` falls in the same cycle `valid`/`frame_err` rises.
- No FIFO, no overrun detection: the consumer must read `data_out` within 1 frame time; the next good frame overwrites it.

Test Plan (20 ns clk, CLKFREQ=50M, BAUDS=9600, bit = 104_167 ns):
- Send 8N1 frame 0xA5 on `rx` at the true baud -> exactly one `valid` pulse, `data_out`=8'hA5, `frame_err` never 1, `busy` 1 during the frame then 0.
- Loop back the team's TX top `tx` into `rx`; send 0xA5, then 0x3C 2 ms later -> two `valid` pulses, `data_out` 8'hA5 then 8'h3C.
- Drive `rx` low for 2_000 ns, then high -> no `valid`/`frame_err`; `busy` returns to 0 by about 52 µs; a following 0x3C frame is received correctly.
- Frame 0x55 with stop bit forced low, then line high -> one `frame_err` pulse, no `valid`, `data_out` keeps its prior value.
- Back-to-back frames 0x00, 0xFF with zero idle gap, and with baud skewed ±2% -> both received, 2 `valid` pulses, correct data.
- Assert `rst` for 100 ns mid-way through data bit 4 of 0xA5 -> all outputs 0 immediately, no pulse for the aborted frame, next frame 0x3C received correctly.
